// File: rtl/gpu_pkg.sv
// Definitions shared by the display command path: command codes, the queued
// entry layout and the issue FSM encoding used by gpu_cmd_queue and gpu.
package gpu_pkg;

   localparam int GPU_CMD_W   = 4;
   localparam int GPU_ENTRY_W = 44;

   localparam logic [GPU_CMD_W-1:0] CMD_NOP   = 4'd0;
   localparam logic [GPU_CMD_W-1:0] CMD_CLEAR = 4'd1;
   localparam logic [GPU_CMD_W-1:0] CMD_DRAW  = 4'd2;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SUBMIT     = 2'd1,
      ST_WAIT_READY = 2'd2
   } issue_state_t;

   // Field order matches the packed entry {cmd, offset, x, y, length}.
   typedef struct packed {
      logic [GPU_CMD_W-1:0] cmd;
      logic [15:0]          offset;
      logic [7:0]           x;
      logic [7:0]           y;
      logic [7:0]           length;
   } gpu_entry_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO with occupancy outputs and a view of the newest entry's
// leading field so the owner can inspect what was pushed last.
module gpu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 44,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [TAG_W-1:0]         o_tail_tag,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [AW-1:0]    w_tail_ptr;
   logic [WIDTH-1:0] w_tail;
   logic             w_push;
   logic             w_pop;

   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && !o_empty;
   assign w_tail_ptr = r_wr_ptr - 1'b1;
   assign w_tail     = r_mem[w_tail_ptr];

   assign o_head     = r_mem[r_rd_ptr];
   assign o_tail_tag = w_tail[WIDTH-1 -: TAG_W];
   assign o_level    = r_count;
   assign o_full     = (r_count == FULL_CNT);
   assign o_empty    = (r_count == '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Command queue between the CPU execute stage and gpu: buffers CLS/DXYN,
// merges back-to-back clears, issues one command per gpu_ready and watches for a hung GPU.
module gpu_cmd_queue
   import gpu_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STALL_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cpu_cmd_valid,
   output logic                   cpu_cmd_ready,
   input  logic [3:0]             cpu_cmd,
   input  logic [15:0]            cpu_draw_offset,
   input  logic [7:0]             cpu_draw_x,
   input  logic [7:0]             cpu_draw_y,
   input  logic [7:0]             cpu_draw_length,
   output logic [3:0]             gpu_cmd,
   output logic [15:0]            gpu_draw_offset,
   output logic [7:0]             gpu_draw_x,
   output logic [7:0]             gpu_draw_y,
   output logic [7:0]             gpu_draw_length,
   output logic                   gpu_cmd_submitted,
   input  logic                   gpu_ready,
   output logic [$clog2(DEPTH):0] queue_level,
   output logic                   gpu_idle,
   output logic                   gpu_stall,
   output issue_state_t           dbg_state
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] LVL_ONE   = LW'(1);
   localparam logic [15:0]   STALL_LIM = 16'(STALL_CYCLES);

   issue_state_t            r_state;
   gpu_entry_t              r_out;
   logic                    r_submitted;
   logic [15:0]             r_wdog;
   logic                    r_stall;

   gpu_entry_t              w_push_entry;
   gpu_entry_t              w_head;
   logic [GPU_CMD_W-1:0]    w_tail_cmd;
   logic [LW-1:0]           w_level;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push_hs;
   logic                    w_issue;
   logic                    w_coalesce;
   logic                    w_fifo_push;

   // Handshake: a command transfers on any rising edge where cpu_cmd_valid and
   // cpu_cmd_ready are both high; ready depends only on occupancy, never on valid.
   assign cpu_cmd_ready = !w_full;
   assign w_push_hs     = cpu_cmd_valid && cpu_cmd_ready;
   assign w_push_entry  = {cpu_cmd, cpu_draw_offset, cpu_draw_x, cpu_draw_y, cpu_draw_length};

   assign w_issue = ((r_state == ST_IDLE) || (r_state == ST_WAIT_READY)) && gpu_ready && !w_empty;

   // A repeated clear is redundant unless the earlier clear leaves the FIFO this cycle.
   assign w_coalesce  = w_push_hs && (cpu_cmd == CMD_CLEAR) && !w_empty &&
                        (w_tail_cmd == CMD_CLEAR) && !(w_issue && (w_level == LVL_ONE));
   assign w_fifo_push = w_push_hs && !w_coalesce;

   gpu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (GPU_ENTRY_W),
      .TAG_W (GPU_CMD_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_fifo_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_issue),
      .o_head      (w_head),
      .o_tail_tag  (w_tail_cmd),
      .o_level     (w_level),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_out       <= '0;
         r_submitted <= 1'b0;
         r_wdog      <= '0;
         r_stall     <= 1'b0;
      end else begin
         r_submitted <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_out       <= w_head;
                  r_submitted <= 1'b1;
                  r_state     <= ST_SUBMIT;
               end
            end
            ST_SUBMIT: begin
               r_wdog  <= '0;
               r_state <= ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
               if (gpu_ready) begin
                  r_wdog <= '0;
                  if (w_issue) begin
                     r_out       <= w_head;
                     r_submitted <= 1'b1;
                     r_state     <= ST_SUBMIT;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  // Saturate so a long hang cannot wrap the counter.
                  if (r_wdog != STALL_LIM) begin
                     r_wdog <= r_wdog + 16'd1;
                  end
                  if (r_wdog + 16'd1 == STALL_LIM) begin
                     r_stall <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gpu_cmd           = r_out.cmd;
   assign gpu_draw_offset   = r_out.offset;
   assign gpu_draw_x        = r_out.x;
   assign gpu_draw_y        = r_out.y;
   assign gpu_draw_length   = r_out.length;
   assign gpu_cmd_submitted = r_submitted;
   assign gpu_stall         = r_stall;
   assign queue_level       = w_level;
   assign gpu_idle          = w_empty && (r_state == ST_IDLE) && gpu_ready;
   assign dbg_state         = r_state;

endmodule

// File: doc/gpu_cmd_queue.md
# gpu_cmd_queue

Buffers display commands from the CPU execute stage and hands them one at a time to `gpu` over its `gpu_cmd_submitted`/`gpu_ready` handshake. The block sits directly upstream of `gpu`. It lets the CPU continue after issuing CLS (00E0) or DXYN while the GPU is still busy. It also coalesces back-to-back clears, reports queue occupancy, and flags a GPU that never returns to ready.

## Interface
- `DEPTH`, 4: number of FIFO entries; power of two, at least 2.
- `STALL_CYCLES`, 65535: number of cycles in WAIT_READY before `gpu_stall` sets; range 1..65535.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_cmd_valid`  in  1  CPU presents a command.
- `cpu_cmd_ready`  out  1  queue accepts; equals `!full`, purely combinational from the count.
- `cpu_cmd`  in  4  command code (see gpu_pkg).
- `cpu_draw_offset`  in  16  sprite address (I register).
- `cpu_draw_x`, `cpu_draw_y`, `cpu_draw_length`  in  8 each  draw coordinates and sprite rows.
- `gpu_cmd`  out  4  registered, to `gpu`.
- `gpu_draw_offset`  out  16  registered, to `gpu`.
- `gpu_draw_x`, `gpu_draw_y`, `gpu_draw_length`  out  8 each  registered, to `gpu`.
- `gpu_cmd_submitted`  out  1  registered single-cycle strobe.
- `gpu_ready`  in  1  from `gpu`.
- `queue_level`  out  $clog2(DEPTH)+1  number of occupied entries.
- `gpu_idle`  out  1  asserted when the FIFO is empty, the FSM is in IDLE, and `gpu_ready` is high.
- `gpu_stall`  out  1  sticky watchdog flag.

## Operation
- Push occurs when `cpu_cmd_valid && cpu_cmd_ready`.
  - An entry is 44 bits: {cmd, offset, x, y, length}.
  - Codes are forwarded unchanged; no validation is done here.
- Clear coalescing: a pushed CMD_CLEAR is not written when all of the following hold. The handshake still completes.
  - The FIFO is non-empty.
  - The tail entry is CMD_CLEAR.
  - The tail is not being popped in the same cycle.
- Issue FSM:
  - IDLE: if the FIFO is non-empty and `gpu_ready` is high, load the `gpu_*` fields from the head, pop, set `gpu_cmd_submitted`, and go to SUBMIT.
  - SUBMIT: clear `gpu_cmd_submitted` and go to WAIT_READY. `gpu_ready` is ignored in this state.
  - WAIT_READY: the watchdog counter increments each cycle.
    - If `gpu_ready` is high and the FIFO is non-empty, issue the next command directly and go to SUBMIT.
    - If `gpu_ready` is high and the FIFO is empty, go to IDLE.
    - When the counter reaches STALL_CYCLES, `gpu_stall` sets and stays set until reset. The FSM keeps waiting.
  - The watchdog counter clears on every transition out of WAIT_READY.
- `gpu_*` field outputs hold their value from one issue until the next. They never change while `gpu_cmd_submitted` is high or while in WAIT_READY.
- Push while empty: the entry is first poppable in the following cycle. There is no bypass path.
- `queue_level` updates each cycle as pushes minus pops:
  - push and pop in the same cycle leaves it unchanged;
  - a coalesced push counts as no push.

## Timing
- Reset (async assert, sync release):
  - FSM goes to IDLE; pointers and count go to 0.
  - All `gpu_*` outputs are 0, `gpu_cmd_submitted` = 0, `gpu_stall` = 0, `queue_level` = 0.
  - `cpu_cmd_ready` = 1 and `gpu_idle` follows `gpu_ready`.
- Reset asserted mid-operation discards all queued entries and any in-flight wait. A GPU that is still busy is not our concern.
- Latency: a push at edge E0 with the GPU ready gives `gpu_cmd_submitted` high after edge E1, for exactly one cycle.
- Minimum issue spacing is 2 cycles. The actual spacing is set by how long `gpu` holds `gpu_ready` low.
- When full, `cpu_cmd_ready` = 0. A pop frees a slot that becomes visible in the next cycle.

## Structure
- `gpu_pkg` holds:
  - command codes CMD_NOP=0, CMD_CLEAR=1, CMD_DRAW=2;
  - the GPU_ENTRY_W=44 constant;
  - the issue FSM state encodings.
  The same package is shared with `gpu`.
- Sub-module `gpu_cmd_fifo`: a synchronous FIFO with parameterised DEPTH and width, and level/full/empty outputs. It also exposes the tail entry so the top level can perform the coalescing check.
- The top level contains the issue FSM, the output registers, the watchdog and the coalescing logic.

## Test plan
- Single DRAW (offset 0x0200, x=10, y=5, length 5) pushed with `gpu_ready`=1:
  - `gpu_cmd_submitted` pulses one cycle after the push, with exact field values;
  - the model drops ready for 3 cycles, after which `gpu_idle` returns to 1.
- Push 4 commands while `gpu_ready`=0:
  - `queue_level` reaches 4 and `cpu_cmd_ready` goes to 0;
  - a 5th valid command is held until ready releases;
  - all 5 commands are issued in order.
- CLEAR, CLEAR, DRAW pushed while the GPU is busy:
  - `queue_level` = 2;
  - only one CLEAR reaches the GPU.
- Model with `gpu_ready` stuck low and STALL_CYCLES=8:
  - `gpu_stall` sets exactly 8 cycles into WAIT_READY;
  - it stays set after ready returns;
  - the next command then issues normally.
- Assert `rst_n` low with 3 entries queued and the FSM in WAIT_READY:
  - all outputs take their reset values immediately;
  - no `gpu_cmd_submitted` pulse occurs after release.
- Randomised back-to-back pushes against a model with ready latency of 1–5 cycles: the scoreboard shows no loss, duplication or reordering, apart from the specified CLEAR coalescing.
